// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract controller.
// One 1-bit add/sub cell processes the latched operands LSB first, one bit per clock.
// A three-state FSM (idle, run, done) sequences the operation; result and carry_out
// are only updated on the edge that processes the final bit.
module serial_addsub_ctrl #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sel,
    input  logic [N-1:0] a_input,
    input  logic [N-1:0] b_input,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic            sel_q, sel_d;
    logic            carry_q, carry_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [N-1:0]    sh_q, sh_d;
    logic [N-1:0]    result_q, result_d;
    logic            cout_q, cout_d;

    logic            a_bit;
    logic            b_bit;
    logic            sum_bit;
    logic            carry_next;
    logic            last_bit;
    logic [N-1:0]    sh_shifted;

    // Single add/sub cell operating on the bit selected by the counter.
    always_comb begin
        a_bit   = a_q[cnt_q];
        b_bit   = b_q[cnt_q];
        sum_bit = a_bit ^ b_bit ^ carry_q;
        if (sel_q) begin
            // Borrow out of a - b - borrow_in.
            carry_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & carry_q);
        end else begin
            carry_next = (a_bit & b_bit) | ((a_bit ^ b_bit) & carry_q);
        end
        last_bit   = (cnt_q == CntW'(N - 1));
        // New bit enters at the MSB so that after N shifts bit 0 sits at position 0.
        sh_shifted = {sum_bit, sh_q[N-1:1]};
    end

    // Next-state and datapath load logic.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sel_d    = sel_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sh_d     = sh_q;
        result_d = result_q;
        cout_d   = cout_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a_input;
                    b_d     = b_input;
                    sel_d   = sel;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                // start is ignored here; operands stay frozen until completion.
                sh_d    = sh_shifted;
                carry_d = carry_next;
                if (last_bit) begin
                    cnt_d    = '0;
                    result_d = sh_shifted;
                    cout_d   = carry_next;
                    state_d  = StDone;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            sel_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sel_q    <= sel_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    // Status flags decode directly from the state register.
    always_comb begin
        busy      = (state_q == StRun);
        done      = (state_q == StDone);
        result    = result_q;
        carry_out = cout_q;
    end

endmodule
